// File: rtl/muldiv_ctrl_pkg.sv
// Shared types for the RV32M multiply/divide sequencer: op encodings, FSM
// states and the per-op control flags latched at acceptance.
package rv32i_types;

  typedef enum logic [2:0] {
    FN_MUL    = 3'd0,
    FN_MULH   = 3'd1,
    FN_MULHSU = 3'd2,
    FN_MULHU  = 3'd3,
    FN_DIV    = 3'd4,
    FN_DIVU   = 3'd5,
    FN_REM    = 3'd6,
    FN_REMU   = 3'd7
  } muldiv_funct3_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } muldiv_state_t;

  typedef struct packed {
    logic hi_half;  // multiply returns product[2W-1:W]
    logic is_rem;   // divide returns the remainder
    logic neg_quo;  // quotient needs negating
    logic neg_rem;  // remainder needs negating
  } muldiv_ctl_t;

  function automatic logic is_div_op(muldiv_funct3_t f);
    return f inside {FN_DIV, FN_DIVU, FN_REM, FN_REMU};
  endfunction

  function automatic logic is_signed_div(muldiv_funct3_t f);
    return f inside {FN_DIV, FN_REM};
  endfunction

  function automatic logic is_rem_op(muldiv_funct3_t f);
    return f inside {FN_REM, FN_REMU};
  endfunction

endpackage

// File: rtl/muldiv_ctrl_div_iter.sv
// Restoring divider on unsigned magnitudes, one quotient bit per step.
// quotient/remainder show the values the registers take after the current step.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] quo_q, rem_q, dsr_q;
  logic [WIDTH-1:0] quo_d, rem_d;
  logic [WIDTH:0]   partial, trial;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    partial = {rem_q, quo_q[WIDTH-1]};
    trial   = partial - {1'b0, dsr_q};
    rem_d   = partial[WIDTH-1:0];
    quo_d   = {quo_q[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_d    = trial[WIDTH-1:0];
      quo_d[0] = 1'b1;
    end
  end

  assign quotient  = quo_d;
  assign remainder = rem_d;

  // NOTE: datapath registers carry no reset; load always initialises them before use.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dsr_q <= divisor;
    end else if (step) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// RV32M multiply/divide sequencer: accepts an M-op from EX, stalls the front
// end while the multiplier or iterative divider runs, then pulses done.
module muldiv_ctrl
  import rv32i_types::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_ITERS  = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int MAX_CNT = (MUL_CYCLES > DIV_ITERS) ? MUL_CYCLES : DIV_ITERS;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  muldiv_state_t      state_q;
  logic [CNT_W-1:0]   count_q;
  logic               done_q;
  logic [WIDTH-1:0]   result_q;
  muldiv_ctl_t        ctl_q, ctl_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  muldiv_funct3_t     op;
  logic               op_div, op_sdiv, a_neg, b_neg;
  logic               div_zero, div_ovf, special, accept;
  logic [WIDTH-1:0]   a_mag, b_mag, special_res;
  logic               mul_a_sgn, mul_b_sgn;
  logic [2*WIDTH-1:0] mul_a, mul_b;
  logic [WIDTH-1:0]   quo, rem, quo_fix, rem_fix, div_res, mul_res;
  logic               div_load, div_step;

  // Operand decode for the op currently presented by EX.
  assign op       = muldiv_funct3_t'(funct3);
  assign op_div   = is_div_op(op);
  assign op_sdiv  = is_signed_div(op);
  assign a_neg    = op_sdiv && a[WIDTH-1];
  assign b_neg    = op_sdiv && b[WIDTH-1];
  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;
  assign div_zero = (b == '0);
  assign div_ovf  = op_sdiv && (a == MIN_NEG) && (b == '1);
  assign special  = op_div && (div_zero || div_ovf);
  assign accept   = start && !flush && !rst;

  always_comb begin
    special_res = '0;
    if (div_zero)     special_res = is_rem_op(op) ? a : '1;
    else if (div_ovf) special_res = is_rem_op(op) ? '0 : MIN_NEG;
  end

  assign ctl_d = '{hi_half: (op != FN_MUL),
                   is_rem:  is_rem_op(op),
                   neg_quo: a_neg ^ b_neg,
                   neg_rem: a_neg};

  // Extending both operands to 2W bits gives the low 2W bits of the 33x33 signed product.
  assign mul_a_sgn = (op == FN_MULH || op == FN_MULHSU) && a[WIDTH-1];
  assign mul_b_sgn = (op == FN_MULH) && b[WIDTH-1];
  assign mul_a     = {{WIDTH{mul_a_sgn}}, a};
  assign mul_b     = {{WIDTH{mul_b_sgn}}, b};
  assign product_d = mul_a * mul_b;

  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && accept) begin
      ctl_q     <= ctl_d;
      product_q <= product_d;
    end
  end

  assign div_load = (state_q == S_IDLE) && accept && op_div && !special;
  assign div_step = (state_q == S_DIV) && !flush && !rst;

  div_iter #(.WIDTH(WIDTH)) u_div_iter (
    .clk      (clk),
    .load     (div_load),
    .step     (div_step),
    .dividend (a_mag),
    .divisor  (b_mag),
    .quotient (quo),
    .remainder(rem)
  );

  assign quo_fix = ctl_q.neg_quo ? -quo : quo;
  assign rem_fix = ctl_q.neg_rem ? -rem : rem;
  assign div_res = ctl_q.is_rem ? rem_fix : quo_fix;
  assign mul_res = ctl_q.hi_half ? product_q[2*WIDTH-1:WIDTH] : product_q[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else if (flush) begin
      state_q <= S_IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if (special) begin
              result_q <= special_res;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else if (op_div) begin
              count_q <= CNT_W'(DIV_ITERS);
              state_q <= S_DIV;
            end else begin
              count_q <= CNT_W'(MUL_CYCLES);
              state_q <= S_MUL;
            end
          end
        end
        S_MUL: begin
          count_q <= count_q - 1'b1;
          if (count_q == CNT_W'(1)) begin
            result_q <= mul_res;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        S_DIV: begin
          count_q <= count_q - 1'b1;
          if (count_q == CNT_W'(1)) begin
            result_q <= div_res;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        S_DONE: state_q <= S_IDLE;
      endcase
    end
  end

  // DONE drops stall so the pipeline advances in the same cycle the result is consumed.
  assign stall  = !rst && !flush &&
                  (((state_q == S_IDLE) && start) || state_q == S_MUL || state_q == S_DIV);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomised self-checking bench for muldiv_ctrl against an arithmetic reference
// model of RV32M results and the cycle-level stall/done timeline.
module tb_muldiv_ctrl;

  localparam int MUL_CYCLES = 2;
  localparam int DIV_ITERS  = 32;

  localparam logic [2:0] F_MUL = 3'd0, F_MULH = 3'd1, F_MULHSU = 3'd2, F_MULHU = 3'd3;
  localparam logic [2:0] F_DIV = 3'd4, F_DIVU = 3'd5, F_REM = 3'd6, F_REMU = 3'd7;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  funct3;
  logic [31:0] a, b;
  logic        stall, done;
  logic [31:0] result;

  logic        exp_stall, exp_done;
  logic [31:0] exp_result;
  int          n_cmp = 0;
  int          n_fail = 0;

  muldiv_ctrl #(.WIDTH(32), .MUL_CYCLES(MUL_CYCLES), .DIV_ITERS(DIV_ITERS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .funct3(funct3),
    .a     (a),
    .b     (b),
    .flush (flush),
    .stall (stall),
    .done  (done),
    .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: RV32M semantics written with plain integer arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] av,
                                             input logic [31:0] bv);
    int          sa, sb;
    longint      p;
    logic [63:0] u;
    sa = av;
    sb = bv;
    case (f3)
      F_MUL:    begin u = {32'b0, av} * {32'b0, bv}; return u[31:0]; end
      F_MULH:   begin p = longint'(sa) * longint'(sb); return p[63:32]; end
      F_MULHSU: begin p = longint'(sa) * longint'({32'b0, bv}); return p[63:32]; end
      F_MULHU:  begin u = {32'b0, av} * {32'b0, bv}; return u[63:32]; end
      F_DIV: begin
        if (bv == 32'd0) return 32'hFFFF_FFFF;
        if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      F_DIVU:   return (bv == 32'd0) ? 32'hFFFF_FFFF : av / bv;
      F_REM: begin
        if (bv == 32'd0) return av;
        if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default:  return (bv == 32'd0) ? av : av % bv;
    endcase
  endfunction

  // Cycle (relative to acceptance) in which done must pulse.
  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] av,
                                     input logic [31:0] bv);
    if (f3 < F_DIV) return MUL_CYCLES + 1;
    if (bv == 32'd0) return 1;
    if ((f3 == F_DIV || f3 == F_REM) && av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) return 1;
    return DIV_ITERS + 1;
  endfunction

  // Compare process: outputs are meaningful on every cycle once the bench runs.
  always @(negedge clk) begin
    check("stall", {31'b0, stall}, {31'b0, exp_stall});
    check("done", {31'b0, done}, {31'b0, exp_done});
    check("result", result, exp_result);
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      start     = 1'b0;
      flush     = 1'b0;
      rst       = 1'b0;
      funct3    = 3'($urandom_range(7));
      a         = $urandom;
      b         = $urandom;
      exp_stall = 1'b0;
      exp_done  = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  // Drives one op (start held while stalled). abort_at >= 0 raises flush or rst
  // in that cycle; lit (if has_lit) is the result the op must leave on the port.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] av, input logic [31:0] bv,
                       input int abort_at, input bit use_rst, input bit has_lit,
                       input logic [31:0] lit);
    logic [31:0] r;
    int          lat;
    bit          abort_now;
    r   = ref_result(f3, av, bv);
    lat = ref_latency(f3, av, bv);
    if (has_lit && abort_at < 0) check("model_pin", r, lit);
    for (int k = 0; k <= lat; k++) begin
      abort_now = (k == abort_at);
      start     = 1'b1;
      funct3    = f3;
      a         = av;
      b         = bv;
      flush     = abort_now && !use_rst;
      rst       = abort_now && use_rst;
      exp_stall = !abort_now && (k < lat);
      exp_done  = !abort_now && (k == lat);
      if (exp_done) exp_result = r;
      if (exp_done && has_lit) check("lit_result", result, lit);
      @(posedge clk); #1;
      if (abort_now) begin
        if (use_rst) exp_result = 32'd0;
        idle(1);
        if (has_lit) check("lit_after_abort", result, lit);
        return;
      end
    end
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0]  f3;
    logic [31:0] av, bv;
    int          lat, ab;

    // Reset with a pending M-op: stall must stay low while rst is high.
    rst        = 1'b1;
    start      = 1'b1;
    flush      = 1'b0;
    funct3     = F_DIV;
    a          = 32'd100;
    b          = 32'd7;
    exp_stall  = 1'b0;
    exp_done   = 1'b0;
    exp_result = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    idle(1);

    do_op(F_MUL,    32'd7,          32'hFFFF_FFFD, -1, 0, 1, 32'hFFFF_FFEB);
    idle(1);
    do_op(F_MULH,   32'h8000_0000,  32'h8000_0000, -1, 0, 1, 32'h4000_0000);
    do_op(F_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, -1, 0, 1, 32'hFFFF_FFFE);
    do_op(F_MULHSU, 32'hFFFF_FFFF,  32'd2,         -1, 0, 1, 32'hFFFF_FFFF);
    idle(2);
    do_op(F_DIV,    32'hFFFF_FFF9,  32'd2,         -1, 0, 1, 32'hFFFF_FFFD);
    do_op(F_REM,    32'hFFFF_FFF9,  32'd2,         -1, 0, 1, 32'hFFFF_FFFF);
    do_op(F_DIVU,   32'd100,        32'd7,         -1, 0, 1, 32'd14);
    idle(1);
    do_op(F_DIVU,   32'd5,          32'd0,         -1, 0, 1, 32'hFFFF_FFFF);
    do_op(F_REMU,   32'd5,          32'd0,         -1, 0, 1, 32'd5);
    do_op(F_DIV,    32'h8000_0000,  32'hFFFF_FFFF, -1, 0, 1, 32'h8000_0000);
    do_op(F_REM,    32'h8000_0000,  32'hFFFF_FFFF, -1, 0, 1, 32'd0);
    idle(1);

    // Flush mid-divide leaves the previous result (0) on the port.
    do_op(F_DIV,    32'd1000,       32'd3,         10, 0, 1, 32'd0);
    do_op(F_MUL,    32'd3,          32'd4,         -1, 0, 1, 32'd12);
    idle(1);

    // Back-to-back, then the same divide killed by reset in its cycle 5.
    do_op(F_DIVU,   32'd9,          32'd3,         -1, 0, 1, 32'd3);
    do_op(F_MUL,    32'd5,          32'd5,         -1, 0, 1, 32'd25);
    do_op(F_DIVU,   32'd9,          32'd3,          5, 1, 1, 32'd0);
    idle(1);

    for (int i = 0; i < 40; i++) begin
      f3  = 3'($urandom_range(7));
      av  = rand_operand();
      bv  = rand_operand();
      lat = ref_latency(f3, av, bv);
      ab  = -1;
      if ($urandom_range(5) == 0) ab = int'($urandom_range(lat - 1));
      do_op(f3, av, bv, ab, 0, 0, 32'd0);
      if ($urandom_range(2) == 0) idle(int'($urandom_range(1, 2)));
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Sequences a shared multi-cycle RV32M multiply/divide resource alongside the EX-stage ALU.
- When EX holds an M-extension op, the block captures the operands and holds the front of the pipeline with stall.
- It runs the multiplier or the iterative divider, then presents the 32-bit result with a one-cycle done pulse.
- It handles the RISC-V divide special cases and pipeline flush.

Parameters:
- WIDTH, 32, operand/result width.
- MUL_CYCLES, 2, multiplier busy cycles (≥1), allowing a retimed multiplier.
- DIV_ITERS, WIDTH, restoring-divider iterations.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- start  input  1  EX holds a valid M-extension op
- funct3  input  3  muldiv op (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
- a  input  WIDTH  rs1 operand (post-forwarding)
- b  input  WIDTH  rs2 operand (post-forwarding)
- flush  input  1  kill the in-flight op (branch/jump redirect)
- stall  output  1  freeze IF..EX pipeline registers
- done  output  1  one-cycle pulse; result valid
- result  output  WIDTH  op result, held until the next done

Behaviour:
- Clocking and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: state=IDLE, counter=0, done=0, result=0. stall=0 while rst is high.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - On start && !flush, latch a, b, funct3, sign flags and the op class.
  - DIV/DIVU/REM/REMU with b==0 → DONE. Quotient=all-ones; remainder=a.
  - DIV/REM with a==0x80000000 and b==0xFFFFFFFF → DONE. DIV=0x80000000; REM=0.
  - Otherwise, MUL class → MUL with counter=MUL_CYCLES. Divide class → DIV with counter=DIV_ITERS.
- MUL:
  - Operates on a 33x33 signed product of operands extended per op: MULH signed/signed, MULHSU signed/unsigned, MULHU and MUL unsigned/unsigned.
  - Counter decrements each cycle; at 1 → DONE.
  - MUL returns product[31:0]; the MULH variants return product[63:32].
- DIV:
  - Restoring division on operand magnitudes, one quotient bit per cycle.
  - Counter at 1 → DONE.
  - Sign fix-up: quotient negated if signs differ (signed ops only); remainder takes the dividend's sign.
- DONE:
  - done=1 for exactly one cycle; result registered on entry. Next state is IDLE.
  - start is ignored here, because the same instruction is still in EX and advances at this edge.
- stall, combinational:
  - High when (state==IDLE && start && !flush) or state is MUL or DIV.
  - Low in DONE, so the result is consumed the same cycle the pipeline advances.
- Latency from the acceptance cycle (cycle 0):
  - Multiply: done in cycle MUL_CYCLES+1.
  - Divide: done in cycle DIV_ITERS+1.
  - Special cases: done in cycle 1.
- Back-to-back M-ops: DONE → IDLE → new acceptance; there is one IDLE cycle between ops, covered by stall from start.
- flush in any state: next state IDLE, done stays 0, result unchanged, stall forced 0 that cycle.
- rst mid-operation: identical to flush, plus result cleared.
- Undefined funct3 encodings are not possible: all 8 values are legal.

Decomposition:
- rv32i_types: muldiv_funct3_t enum (mul=0 … remu=7); muldiv_state_t enum.
- Sub-module div_iter:
  - Holds the remainder/quotient registers and performs one restoring step per enable.
  - Interface: load, step, dividend, divisor → quotient, remainder.
- The multiplier product register lives in muldiv_ctrl.

Test Plan:
- MUL a=7, b=0xFFFFFFFD → result 0xFFFFFFEB. done in cycle 3 (MUL_CYCLES=2); stall high in cycles 0–2, low in cycle 3.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14. done in cycle 33.
- DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0. All done in cycle 1.
- Flush: start DIV, assert flush in cycle 10 → no done pulse, stall low that cycle, IDLE next. A following MUL 3×4 → 12 with normal latency.
- Back-to-back: DIVU 9/3 then MUL 5×5 → done pulses with results 3 then 25, separated by one IDLE cycle. Repeat with rst asserted in cycle 5 of the DIVU → result=0, done never pulses.
